// File: rtl/fir_out_requant_fifo.sv
// Requantizes the FIR output stream (round-half-up, saturate) and buffers it in a
// first-word-fall-through FIFO with a valid/ready consumer side and sticky overflow flag.
module fir_out_requant_fifo #(
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 8,
    parameter int OUT_INTE_WL = 4,
    parameter int OUT_FRAC_WL = 4,
    parameter int DEPTH       = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_INTE_WL+IN_FRAC_WL-1:0]   data_in,
    input  logic                               in_valid,
    output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               overflow,
    output logic                               sat
);
    localparam int IN_W  = IN_INTE_WL + IN_FRAC_WL;
    localparam int OUT_W = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int D     = IN_FRAC_WL - OUT_FRAC_WL;
    localparam int SW    = IN_W + 1 - D;
    localparam int DH    = (D > 0) ? D - 1 : 0;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [IN_W:0]    HALF    = (IN_W+1)'((D > 0) ? (1 << DH) : 0);
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [IN_W:0]     ext;
    logic [IN_W:0]     rounded;
    logic [SW-1:0]     shifted;
    logic [SW-OUT_W:0] top_bits;
    logic              requant_sat;
    logic [OUT_W-1:0]  requant_val;

    logic [OUT_W-1:0]  pipe_data_q, pipe_data_d;
    logic              pipe_valid_q, pipe_valid_d;
    logic              sat_q, sat_d;

    logic [OUT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              pop;
    logic              wr_en;

    // The extra sign bit keeps the rounding add from wrapping near +full-scale.
    always_comb begin
        ext         = {data_in[IN_W-1], data_in};
        rounded     = ext + HALF;
        shifted     = SW'(rounded >> D);
        top_bits    = shifted[SW-1:OUT_W-1];
        requant_sat = !((&top_bits) || !(|top_bits));
        requant_val = shifted[OUT_W-1:0];
        if (requant_sat) begin
            requant_val = shifted[SW-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        pipe_data_d  = requant_val;
        pipe_valid_d = in_valid;
        sat_d        = in_valid & requant_sat;

        full       = (count_q == CW'(DEPTH));
        pop        = (count_q != '0) & out_ready;
        // A full FIFO still accepts the push when the consumer frees a slot this cycle.
        wr_en      = pipe_valid_q & (!full | pop);
        wr_ptr_d   = wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        overflow_d = overflow_q | (pipe_valid_q & full & !pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            sat_q        <= sat_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Datapath storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        pipe_data_q <= pipe_data_d;
        if (wr_en && rst) begin
            mem_q[wr_ptr_q] <= pipe_data_q;
        end
    end

    assign data_out  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_out_requant_fifo.sv
// Bench for fir_out_requant_fifo: directed test-plan scenarios plus random traffic,
// checked by a queue-based reference model and a monitor that compares every cycle.
module tb_fir_out_requant_fifo;
    localparam int IN_INTE_WL  = 4;
    localparam int IN_FRAC_WL  = 8;
    localparam int OUT_INTE_WL = 4;
    localparam int OUT_FRAC_WL = 4;
    localparam int DEPTH       = 8;
    localparam int IN_W        = IN_INTE_WL + IN_FRAC_WL;
    localparam int OUT_W       = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int D           = IN_FRAC_WL - OUT_FRAC_WL;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [IN_W-1:0]  data_in = '0;
    logic             in_valid = 1'b0;
    logic [OUT_W-1:0] data_out;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             sat;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: one-deep pending stage feeding an ideal bounded queue.
    logic [OUT_W-1:0] exp_q[$];
    int               m_count = 0;
    logic             m_ovf = 1'b0;
    logic             m_sat = 1'b0;
    logic             m_pend = 1'b0;
    logic [OUT_W-1:0] m_pend_val = '0;
    logic [OUT_W-1:0] m_y;
    logic             m_s;
    bit               m_pop;

    fir_out_requant_fifo #(
        .IN_INTE_WL (IN_INTE_WL),
        .IN_FRAC_WL (IN_FRAC_WL),
        .OUT_INTE_WL(OUT_INTE_WL),
        .OUT_FRAC_WL(OUT_FRAC_WL),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_valid (in_valid),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requantization from the arithmetic definition: floor((v + half_lsb) / 2^D), clamped.
    function automatic void requant_ref(input logic [IN_W-1:0] x,
                                        output logic [OUT_W-1:0] y, output logic s);
        int v, r, hi, lo;
        v  = int'($signed(x));
        r  = (v + (1 << (D - 1))) >>> D;
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        s  = 1'b0;
        if (r > hi) begin
            r = hi;
            s = 1'b1;
        end
        if (r < lo) begin
            r = lo;
            s = 1'b1;
        end
        y = OUT_W'(r);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_count = 0;
                exp_q.delete();
                m_pend  = 1'b0;
                m_sat   = 1'b0;
                m_ovf   = 1'b0;
            end else begin
                m_pop = (m_count > 0) && out_ready;
                if (m_pend) begin
                    if (m_count < DEPTH || m_pop) begin
                        exp_q.push_back(m_pend_val);
                        m_count++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (m_pop) m_count--;
                requant_ref(data_in, m_y, m_s);
                m_pend     = in_valid;
                m_pend_val = m_y;
                m_sat      = in_valid & m_s;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, m_count > 0);
            chk("count", count, m_count);
            chk("overflow", overflow, m_ovf);
            chk("sat", sat, m_sat);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", data_out, 32'hFFFF_FFFF);
                end else begin
                    chk("data_out", data_out, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic r);
        in_valid  = v;
        data_in   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (!out_valid && m_count == 0 && !m_pend) break;
            cycle(1'b0, '0, 1'b1);
        end
        chk("drain_empty", out_valid, 1'b0);
    endtask

    logic [IN_W-1:0]  t1_in  [4] = '{12'h018, 12'hFF8, 12'h017, 12'h100};
    logic [OUT_W-1:0] t1_exp [4] = '{8'h02, 8'h00, 8'h01, 8'h10};
    logic [IN_W-1:0]  t2_in  [4] = '{12'h7F9, 12'h7FF, 12'h800, 12'h801};
    logic [OUT_W-1:0] t2_exp [4] = '{8'h7F, 8'h7F, 8'h80, 8'h80};
    logic             t2_sat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic             rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic             pre_valid;
        logic [OUT_W-1:0] pre_data;
        logic             v, r;
        int               sent, k;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_sat", sat, 0);
        rst = 1'b1;

        // Rounding with a free-running consumer; first output two edges after acceptance.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cycle(1'b1, t1_in[i], 1'b1);
            else       cycle(1'b0, '0, 1'b1);
            if (i == 0) chk("t1_first_latency", out_valid, 0);
            if (i >= 1 && i <= 4) begin
                chk("t1_valid", out_valid, 1);
                chk("t1_data", data_out, t1_exp[i-1]);
            end
            if (i < 4) chk("t1_sat", sat, 0);
        end
        drain();

        // Saturation at both ends of the range.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cycle(1'b1, t2_in[i], 1'b1);
            else       cycle(1'b0, '0, 1'b1);
            if (i < 4) chk("t2_sat", sat, t2_sat[i]);
            if (i >= 1 && i <= 4) chk("t2_data", data_out, t2_exp[i-1]);
        end
        drain();

        // Fill past capacity with the consumer stalled.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, IN_W'(16 * (i + 1)), 1'b0);
            if (i == 8) begin
                chk("t3_count_full", count, DEPTH);
                chk("t3_no_overflow_yet", overflow, 0);
            end
            if (i == 9) chk("t3_overflow_set", overflow, 1);
        end
        cycle(1'b0, '0, 1'b0);
        chk("t3_count_held", count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain_data", data_out, i + 1);
            cycle(1'b0, '0, 1'b1);
        end
        chk("t3_count_empty", count, 0);
        chk("t3_overflow_sticky", overflow, 1);

        // Reset with five entries buffered and one sample in the requant stage.
        for (int i = 0; i < 6; i++) cycle(1'b1, IN_W'($urandom), 1'b0);
        chk("t6_count_before", count, 5);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0);
        rst = 1'b1;
        chk("t6_count_cleared", count, 0);
        chk("t6_valid_cleared", out_valid, 0);
        chk("t6_overflow_cleared", overflow, 0);
        cycle(1'b1, 12'h030, 1'b1);
        chk("t6_post_latency", out_valid, 0);
        cycle(1'b0, '0, 1'b1);
        chk("t6_post_valid", out_valid, 1);
        chk("t6_post_data", data_out, 8'h03);
        drain();

        // Full FIFO with simultaneous push and pop every cycle.
        for (int i = 0; i < 9; i++) cycle(1'b1, IN_W'($urandom), 1'b0);
        chk("t4_count_full", count, DEPTH);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, IN_W'($urandom), 1'b1);
            chk("t4_count_steady", count, DEPTH);
            chk("t4_no_overflow", overflow, 0);
        end
        drain();

        // Random sparse input against a 1,0,0,1 ready pattern.
        sent = 0;
        k    = 0;
        while (sent < 64 && k < 2000) begin
            v         = ($urandom_range(0, 2) == 0);
            r         = rdy_pat[k % 4];
            pre_valid = out_valid;
            pre_data  = data_out;
            cycle(v, IN_W'($urandom), r);
            if (pre_valid && !r) chk("t5_hold", data_out, pre_data);
            if (v) sent++;
            k++;
        end
        chk("t5_all_sent", sent, 64);
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
